mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_ctrl_pkg.sv | 16 +
 rtl/mux_scan_ctrl_if.sv | 29 ++
 rtl/mux_scan_ctrl_chan_pick.sv | 19 +
 rtl/mux_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the channel-mux scan sequencer.
package mux_scan_ctrl_pkg;

    localparam int CHAN_W    = 3;
    localparam int NUM_CHAN  = 8;
    localparam int CNT_W     = 4;
    localparam int DWELL_MIN = 1;
    localparam int DWELL_MAX = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Control, mux-select and sample-output bundle between the scan sequencer and its neighbours.
interface mux_scan_ctrl_if
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DATA_W = 3
);
    logic                start;
    logic [NUM_CHAN-1:0] chan_mask;
    logic [DATA_W-1:0]   mux_in;
    logic                s1;
    logic                s2;
    logic                s3;
    logic [DATA_W-1:0]   out_data;
    logic [CHAN_W-1:0]   out_chan;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic                done;

    modport slave (
        input  start, chan_mask, mux_in, out_ready,
        output s1, s2, s3, out_data, out_chan, out_valid, busy, done
    );

    modport master (
        output start, chan_mask, mux_in, out_ready,
        input  s1, s2, s3, out_data, out_chan, out_valid, busy, done
    );
endinterface

// File: rtl/mux_scan_ctrl_chan_pick.sv
// Lowest-set-bit priority encoder: picks the next channel to scan from a mask.
module mux_scan_ctrl_chan_pick
    import mux_scan_ctrl_pkg::*;
(
    input  logic [NUM_CHAN-1:0] mask_i,
    output logic [CHAN_W-1:0]   idx_o,
    output logic                any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |mask_i;
        // Descending walk so the lowest set bit is the last write.
        for (int k = NUM_CHAN - 1; k >= 0; k--) begin
            if (mask_i[k]) idx_o = CHAN_W'(k);
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled mux channels in ascending order, dwelling before each capture,
// and hands every sample downstream over valid/ready.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int DWELL  = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    mux_scan_ctrl_if.slave   bus
);

    if (DWELL < DWELL_MIN || DWELL > DWELL_MAX) begin : g_bad_dwell
        $error("mux_scan_ctrl: DWELL out of range");
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DWELL - 1);

    state_t              state_q, state_d;
    logic [NUM_CHAN-1:0] pend_q,  pend_d;
    logic [CHAN_W-1:0]   sel_q,   sel_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [CHAN_W-1:0]   chan_q,  chan_d;
    logic                vld_q,   vld_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;

    logic [NUM_CHAN-1:0] remaining;
    logic [NUM_CHAN-1:0] pick_in;
    logic [CHAN_W-1:0]   pick_idx;
    logic                pick_any;

    // One encoder serves both the start decision and the advance decision.
    assign remaining = pend_q & ~(NUM_CHAN'(1) << sel_q);
    assign pick_in   = (state_q == IDLE) ? bus.chan_mask : remaining;

    mux_scan_ctrl_chan_pick u_pick (
        .mask_i (pick_in),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        chan_d  = chan_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (pick_any) begin
                        pend_d  = bus.chan_mask;
                        sel_d   = pick_idx;
                        cnt_d   = CNT_INIT;
                        busy_d  = 1'b1;
                        state_d = SETTLE;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    data_d  = bus.mux_in;
                    chan_d  = sel_q;
                    vld_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (vld_q && bus.out_ready) begin
                    vld_d  = 1'b0;
                    pend_d = remaining;
                    if (pick_any) begin
                        sel_d   = pick_idx;
                        cnt_d   = CNT_INIT;
                        state_d = SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            chan_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.s3        = sel_q[2];
    assign bus.s1        = sel_q[1];
    assign bus.s2        = sel_q[0];
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = vld_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: table of scan masks plus hand-written corner sequences.
module tb_mux_scan_ctrl;

    localparam int DWELL = 2;

    logic       clk;
    logic       rst_n;
    logic [2:0] mux_xor;
    int         total;
    int         bad;

    mux_scan_ctrl_if #(.DATA_W(3)) bus ();

    mux_scan_ctrl #(.DATA_W(3), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Mux model: returns the selected channel index, optionally scrambled.
    assign bus.mux_in = {bus.s3, bus.s1, bus.s2} ^ mux_xor;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]      mask;
        int              n;
        logic [7:0][2:0] ch;
        bit              inject;
    } vec_t;

    vec_t tbl [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic scan_check(input vec_t v);
        logic [2:0] c;
        bus.start     = 1'b1;
        bus.chan_mask = v.mask;
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        for (int i = 0; i < v.n; i++) begin
            c = v.ch[i];
            chk("sel", 32'({bus.s3, bus.s1, bus.s2}), 32'(c));
            for (int d = 0; d < DWELL; d++) begin
                chk("early_valid", 32'(bus.out_valid), 32'd0);
                if (v.inject && i == 0 && d == 0) begin
                    bus.start     = 1'b1;
                    bus.chan_mask = 8'hFF;
                end
                tick();
                bus.start = 1'b0;
            end
            chk("valid", 32'(bus.out_valid), 32'd1);
            chk("out_chan", 32'(bus.out_chan), 32'(c));
            chk("out_data", 32'(bus.out_data), 32'(c));
            chk("done_during_valid", 32'(bus.done), 32'd0);
            tick();
        end
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("valid_at_done", 32'(bus.out_valid), 32'd0);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        tick();
        chk("done_clear", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        // packed channel lists are written highest slot first
        tbl[0] = '{8'hFF,        8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 1'b0};
        tbl[1] = '{8'b1010_0100, 3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2}, 1'b0};
        tbl[2] = '{8'h01,        1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 1'b0};
        tbl[3] = '{8'h80,        1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}, 1'b0};
        tbl[4] = '{8'b1010_0100, 3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2}, 1'b1};

        mux_xor       = 3'd0;
        bus.start     = 1'b0;
        bus.chan_mask = 8'h00;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        tick();
        tick();
        chk("rst_sel", 32'({bus.s3, bus.s1, bus.s2}), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_chan", 32'(bus.out_chan), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 5; t++) scan_check(tbl[t]);

        // Empty mask: done pulse only.
        bus.start     = 1'b1;
        bus.chan_mask = 8'h00;
        tick();
        bus.start = 1'b0;
        chk("empty_done", 32'(bus.done), 32'd1);
        chk("empty_busy", 32'(bus.busy), 32'd0);
        chk("empty_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("empty_done_clear", 32'(bus.done), 32'd0);
        chk("empty_valid2", 32'(bus.out_valid), 32'd0);

        // Reset while settling on channel 3.
        bus.start     = 1'b1;
        bus.chan_mask = 8'hFF;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 3 * (DWELL + 1); k++) tick();
        chk("pre_rst_sel", 32'({bus.s3, bus.s1, bus.s2}), 32'd3);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_sel", 32'({bus.s3, bus.s1, bus.s2}), 32'd0);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        scan_check(tbl[0]);

        // Backpressure on channel 4 while the mux output changes.
        bus.out_ready = 1'b0;
        bus.start     = 1'b1;
        bus.chan_mask = 8'b0011_0000;
        tick();
        bus.start = 1'b0;
        for (int d = 0; d < DWELL; d++) tick();
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_chan", 32'(bus.out_chan), 32'd4);
        mux_xor = 3'b111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_data", 32'(bus.out_data), 32'd4);
            chk("bp_hold_sel", 32'({bus.s3, bus.s1, bus.s2}), 32'd4);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_handshake_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_next_sel", 32'({bus.s3, bus.s1, bus.s2}), 32'd5);
        for (int d = 0; d < DWELL; d++) tick();
        chk("bp_ch5_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_ch5_chan", 32'(bus.out_chan), 32'd5);
        chk("bp_ch5_data", 32'(bus.out_data), 32'd2);
        mux_xor = 3'd0;
        tick();
        chk("bp_done", 32'(bus.done), 32'd1);
        chk("bp_busy", 32'(bus.busy), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
